// File: rtl/conv_linebuf_gen.sv
`timescale 1ns/1ps
// conv_linebuf_gen: line buffer that turns a raster pixel stream into KxK
// convolution tap beats.
// Latency: first beat of a row is registered one cycle after the pixel that
// completes its last needed input row.
// Backpressure: in_ready drops while the buffer would overwrite live rows;
// outputs hold while valid_out && !out_ready.
// Ports:
//   clk, rst              - single clock, async active-high reset
//   valid_in/in_ready     - pixel handshake, in_data is raster-order pixel
//   valid_out/out_ready   - beat handshake; out_data carries LANES pixels
//   out_tap_row/col       - kernel (k, j) of the current beat
//   row_last              - last beat (k=j=K-1) of an output row
//   frame_done            - one-cycle pulse once the final row is emitted
module conv_linebuf_gen #(
   parameter int WIDTH       = 12,
   parameter int HEIGHT      = 12,
   parameter int DATA_BIT    = 12,
   parameter int KERNEL_SIZE = 5
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            valid_in,
   output logic                                            in_ready,
   input  logic [DATA_BIT-1:0]                             in_data,
   output logic [(WIDTH-KERNEL_SIZE+1)*DATA_BIT-1:0]       out_data,
   output logic [((KERNEL_SIZE>1)?$clog2(KERNEL_SIZE):1)-1:0] out_tap_row,
   output logic [((KERNEL_SIZE>1)?$clog2(KERNEL_SIZE):1)-1:0] out_tap_col,
   output logic                                            valid_out,
   input  logic                                            out_ready,
   output logic                                            row_last,
   output logic                                            frame_done
);

   localparam int K     = KERNEL_SIZE;
   localparam int LANES = WIDTH - K + 1;
   localparam int TW    = (K > 1) ? $clog2(K) : 1;
   localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int RW    = $clog2(HEIGHT + 1);
   localparam int SW    = $clog2(K + 1);

   localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
   localparam logic [TW-1:0] TAP_LAST  = TW'(K - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(K);
   localparam logic [RW-1:0] K_R       = RW'(K);
   localparam logic [RW-1:0] HEIGHT_R  = RW'(HEIGHT);
   localparam logic [RW-1:0] RROW_LAST = RW'(HEIGHT - K);
   localparam logic [RW:0]   K_X       = (RW+1)'(K);

   typedef enum logic [1:0] {FILL, EMIT, DONE} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       wcol, wcol_d;
   logic [RW-1:0]       wrow, wrow_d, rrow, rrow_d;
   logic [SW-1:0]       wslot, wslot_d, rslot, rslot_d, rd_slot;
   logic [TW-1:0]       tk, tk_d, tj, tj_d;
   logic                frame_done_d, valid_d, last_d, in_ready_d;
   logic                wr_en, xfer, hold;
   logic [CW-1:0]       rd_col [LANES];
   logic [LANES*DATA_BIT-1:0] data_d;
   int                  rd_sum;

   // K+1 row slots: one spare row lets input run ahead while K rows are read.
   logic [DATA_BIT-1:0] mem [K+1][WIDTH];

   assign wr_en = valid_in && in_ready;
   assign xfer  = valid_out && out_ready;
   assign hold  = valid_out && !out_ready;

   always_comb begin : next_state
      state_d      = state_q;
      wcol_d       = wcol;
      wrow_d       = wrow;
      wslot_d      = wslot;
      rrow_d       = rrow;
      rslot_d      = rslot;
      tk_d         = tk;
      tj_d         = tj;
      frame_done_d = 1'b0;

      if (wr_en) begin
         if (wcol == COL_LAST) begin
            wcol_d  = '0;
            wrow_d  = wrow + RW'(1);
            wslot_d = (wslot == SLOT_LAST) ? '0 : wslot + SW'(1);
         end else begin
            wcol_d  = wcol + CW'(1);
         end
      end

      // Tap counters name the beat being presented; they move only on transfer.
      if (xfer) begin
         if (tj == TAP_LAST) begin
            tj_d = '0;
            if (tk == TAP_LAST) begin
               tk_d    = '0;
               rrow_d  = rrow + RW'(1);
               rslot_d = (rslot == SLOT_LAST) ? '0 : rslot + SW'(1);
            end else begin
               tk_d    = tk + TW'(1);
            end
         end else begin
            tj_d = tj + TW'(1);
         end
      end

      case (state_q)
         FILL: if (wrow_d >= K_R) state_d = EMIT;
         EMIT: if (xfer && row_last && (rrow == RROW_LAST)) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
            wcol_d       = '0;
            wrow_d       = '0;
            wslot_d      = '0;
            rrow_d       = '0;
            rslot_d      = '0;
            tk_d         = '0;
            tj_d         = '0;
         end
         DONE:    state_d = FILL;
         default: state_d = FILL;
      endcase

      // Outputs are registered, so they are derived from next-state counters.
      valid_d    = (state_d == EMIT) && ({1'b0, wrow_d} >= ({1'b0, rrow_d} + K_X));
      last_d     = valid_d && (tk_d == TAP_LAST) && (tj_d == TAP_LAST);
      in_ready_d = (state_d != DONE) && (wrow_d < HEIGHT_R) &&
                   ({1'b0, wrow_d} <= ({1'b0, rrow_d} + K_X));
   end

   // Slot of input row (r + k), wrapping modulo K+1.
   always_comb begin : read_addr
      rd_sum = int'(rslot_d) + int'(tk_d);
      if (rd_sum > K) rd_sum = rd_sum - (K + 1);
      rd_slot = SW'(rd_sum);
      for (int l = 0; l < LANES; l++) rd_col[l] = CW'(tj_d) + CW'(l);
   end

   // Forward the pixel being written this cycle; only reachable when K=1 and
   // the enabling pixel belongs to the row read by the next beat.
   always_comb begin : read_data
      data_d = '0;
      for (int l = 0; l < LANES; l++) begin
         if (wr_en && (wslot == rd_slot) && (wcol == rd_col[l]))
            data_d[l*DATA_BIT +: DATA_BIT] = in_data;
         else
            data_d[l*DATA_BIT +: DATA_BIT] = mem[rd_slot][rd_col[l]];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wslot][wcol] <= in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FILL;
         wcol        <= '0;
         wrow        <= '0;
         wslot       <= '0;
         rrow        <= '0;
         rslot       <= '0;
         tk          <= '0;
         tj          <= '0;
         in_ready    <= 1'b0;
         frame_done  <= 1'b0;
         valid_out   <= 1'b0;
         row_last    <= 1'b0;
         out_data    <= '0;
         out_tap_row <= '0;
         out_tap_col <= '0;
      end else begin
         state_q    <= state_d;
         wcol       <= wcol_d;
         wrow       <= wrow_d;
         wslot      <= wslot_d;
         rrow       <= rrow_d;
         rslot      <= rslot_d;
         tk         <= tk_d;
         tj         <= tj_d;
         in_ready   <= in_ready_d;
         frame_done <= frame_done_d;
         if (!hold) begin
            valid_out <= valid_d;
            row_last  <= last_d;
            if (valid_d) begin
               out_data    <= data_d;
               out_tap_row <= tk_d;
               out_tap_col <= tj_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_linebuf_gen.sv
`timescale 1ns/1ps
// Bench for conv_linebuf_gen at default parameters; pixel value = row*16+col.
// Expected beats are queued per frame and compared by a negedge monitor.
module tb_conv_linebuf_gen;

   localparam int W = 12, H = 12, DB = 12, K = 5, L = W - K + 1;
   localparam int NB = (H - K + 1) * K * K;  // 200 beats per frame
   localparam int NPIX = W * H;

   logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, out_ready = 1'b1;
   logic [DB-1:0] in_data = '0;
   logic in_ready, valid_out, row_last, frame_done;
   logic [L*DB-1:0] out_data;
   logic [2:0] out_tap_row, out_tap_col;

   always #5 clk = ~clk;

   conv_linebuf_gen dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .in_ready(in_ready),
      .in_data(in_data), .out_data(out_data), .out_tap_row(out_tap_row),
      .out_tap_col(out_tap_col), .valid_out(valid_out), .out_ready(out_ready),
      .row_last(row_last), .frame_done(frame_done)
   );

   typedef struct packed {
      logic [L*DB-1:0] data;
      logic [2:0]      k;
      logic [2:0]      j;
      logic            last;
   } beat_t;

   beat_t exp_q[$];
   beat_t mon_e;
   int errors = 0, checks = 0, cyc = 0;
   bit abort = 1'b0;

   // Observer state (written only by the monitor) and per-frame baselines
   // (written only by the main sequence).
   int beat_cnt = 0, pix_cnt = 0, fd_cnt = 0, bi = 0;
   int pix60_cyc = -100, fv_cyc = -100, fall_cyc = -100, fall_pix = -1;
   int r0_last_cyc = -100, last_beat_cyc = -100, fd_cyc = -100;
   logic rdy_at_r0last = 1'b1, rdy_after_r0last = 1'b0, fd_inrdy = 1'b1, rdy_after_fd = 1'b0;
   int frame_cyc0 = 0, pix_base = 0, beat_base = 0, fd_base = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic beat_t model_beat(input int idx);
      beat_t b;
      int r, k, j;
      r = idx / (K * K);
      k = (idx % (K * K)) / K;
      j = idx % K;
      b.data = '0;
      for (int l = 0; l < L; l++) b.data[l*DB +: DB] = DB'((r + k) * 16 + j + l);
      b.k = 3'(k);
      b.j = 3'(j);
      b.last = (k == K - 1) && (j == K - 1);
      return b;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (cyc == r0_last_cyc + 1) rdy_after_r0last = in_ready;
         if (cyc == fd_cyc + 1) rdy_after_fd = in_ready;
         if (!in_ready && (pix_cnt - pix_base) > 0 && fall_cyc < frame_cyc0) begin
            fall_cyc = cyc;
            fall_pix = pix_cnt - pix_base;
         end
         if (valid_out && fv_cyc < frame_cyc0) fv_cyc = cyc;
         if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
            fd_inrdy = in_ready;
         end
         if (valid_in && in_ready) begin
            pix_cnt++;
            if (pix_cnt - pix_base == 60) pix60_cyc = cyc;
         end
         if (valid_out && out_ready) begin
            bi = beat_cnt - beat_base;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: beat %0d arrived, none expected", bi);
            end else begin
               mon_e = exp_q.pop_front();
               chk("beat_data", out_data, mon_e.data);
               chk("beat_tap_row", out_tap_row, mon_e.k);
               chk("beat_tap_col", out_tap_col, mon_e.j);
               chk("beat_row_last", row_last, mon_e.last);
               if (bi == 0) begin
                  chk("beat0_lane0", out_data[0 +: DB], 12'h000);
                  chk("beat0_lane7", out_data[7*DB +: DB], 12'h007);
               end
               if (bi == 24) begin
                  chk("beat24_lane0", out_data[0 +: DB], 12'h044);
                  chk("beat24_lane7", out_data[7*DB +: DB], 12'h04B);
               end
            end
            if (bi == K * K - 1) begin
               r0_last_cyc = cyc;
               rdy_at_r0last = in_ready;
            end
            if (bi == NB - 1) last_beat_cyc = cyc;
            beat_cnt++;
         end
      end
   end

   task automatic drive_pixels();
      int guard;
      for (int p = 0; p < NPIX && !abort; p++) begin
         valid_in = 1'b1;
         in_data = DB'((p / W) * 16 + p % W);
         guard = 0;
         do begin
            @(negedge clk);
            guard++;
         end while (!(in_ready && !rst) && !abort && guard < 3000);
         if (abort) break;
         if (guard >= 3000) begin
            checks++;
            errors++;
            $display("FAIL pixel_timeout: pixel %0d not accepted, in_ready=%0b", p, in_ready);
            break;
         end
         @(posedge clk);
         #1;
      end
      valid_in = 1'b0;
   endtask

   task automatic control_out(input bit do_stall, input bit do_abort);
      int guard;
      logic [103:0] snap;
      if (do_stall) begin
         guard = 0;
         while (!((beat_cnt - beat_base) == 82 && valid_out) && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
         end
         if (guard >= 5000) begin
            checks++;
            errors++;
            $display("FAIL stall_point: beat 82 not presented, beats=%0d", beat_cnt - beat_base);
         end else begin
            chk("stall_tap_row", out_tap_row, 3'd1);
            chk("stall_tap_col", out_tap_col, 3'd2);
            snap = {valid_out, row_last, out_tap_row, out_tap_col, out_data};
            out_ready = 1'b0;
            for (int i = 0; i < 10; i++) begin
               @(posedge clk);
               #1;
               chk("stall_frozen", {valid_out, row_last, out_tap_row, out_tap_col, out_data}, snap);
            end
            out_ready = 1'b1;
         end
      end
      guard = 0;
      if (do_abort) begin
         while (!((beat_cnt - beat_base) == 63 && valid_out) && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
         end
         if (guard >= 5000) begin
            checks++;
            errors++;
            $display("FAIL abort_point: beat 63 not presented, beats=%0d", beat_cnt - beat_base);
            abort = 1'b1;
         end else begin
            chk("abort_point_taps", {out_tap_row, out_tap_col}, {3'd2, 3'd3});
            #2;
            rst = 1'b1;
            abort = 1'b1;
            #1;
            chk("arst_valid_out", valid_out, 1'b0);
            chk("arst_in_ready", in_ready, 1'b0);
            chk("arst_out_data", out_data, '0);
            chk("arst_taps", {out_tap_row, out_tap_col}, 6'd0);
            chk("arst_row_last", row_last, 1'b0);
            chk("arst_frame_done", frame_done, 1'b0);
            exp_q.delete();
            repeat (3) @(posedge clk);
            #3;
            rst = 1'b0;
            @(posedge clk);
            #1;
         end
      end else begin
         while ((beat_cnt - beat_base) < NB && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
         end
         if (guard >= 5000) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: beats=%0d, required %0d", beat_cnt - beat_base, NB);
         end
         repeat (4) @(posedge clk);
         #1;
      end
   endtask

   task automatic run_frame(input bit do_stall, input bit do_abort);
      frame_cyc0 = cyc;
      pix_base = pix_cnt;
      beat_base = beat_cnt;
      fd_base = fd_cnt;
      abort = 1'b0;
      for (int i = 0; i < NB; i++) exp_q.push_back(model_beat(i));
      fork
         drive_pixels();
         control_out(do_stall, do_abort);
      join
      if (!do_abort) begin
         chk("beats_total", beat_cnt - beat_base, NB);
         chk("queue_empty", exp_q.size(), 0);
         chk("first_valid_latency", fv_cyc, pix60_cyc + 1);
         chk("in_ready_fall_pixels", fall_pix, 72);
         chk("in_ready_at_row0_last", rdy_at_r0last, 1'b0);
         chk("in_ready_after_row0_last", rdy_after_r0last, 1'b1);
         chk("frame_done_pulses", fd_cnt - fd_base, 1);
         chk("frame_done_timing", fd_cyc, last_beat_cyc + 1);
         chk("in_ready_in_done", fd_inrdy, 1'b0);
         chk("in_ready_after_done", rdy_after_fd, 1'b1);
      end
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid_out", valid_out, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_data", out_data, '0);
      chk("rst_taps", {out_tap_row, out_tap_col}, 6'd0);
      chk("rst_row_last", row_last, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk("in_ready_before_edge", in_ready, 1'b0);
      @(posedge clk);
      #1;
      chk("in_ready_first_edge", in_ready, 1'b1);

      run_frame(1'b1, 1'b0);  // full frame with a 10-cycle stall at row 3 beat 7
      run_frame(1'b0, 1'b0);  // back-to-back frame, same beat stream
      run_frame(1'b0, 1'b1);  // reset mid-EMIT at row 2 beat 13
      run_frame(1'b0, 1'b0);  // fresh frame after reset

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
